// File: rtl/lcd_timing_gen_pkg.sv
// Purpose : shared timing constants, region enum and helpers for the TFT-LCD timing generator.
// Latency : n/a (compile-time definitions only).
// Backpressure: n/a.
package lcd_timing_pkg;

    // Default 480x272 panel timing (pixels / lines)
    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 2;
    localparam int DEF_H_SYNC   = 41;
    localparam int DEF_H_BP     = 2;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_V_SYNC   = 10;
    localparam int DEF_V_BP     = 2;

    // Both raster counters are exported as 10-bit positions
    localparam int CNT_W = 10;

    // Regions along one axis, in scan order
    typedef enum logic [1:0] {
        RGN_ACTIVE,
        RGN_FRONT,
        RGN_SYNC,
        RGN_BACK
    } region_e;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Classify a position on one axis; the back porch runs to the end of the axis
    function automatic region_e region_of(input int pos, input int act, input int fp, input int sync);
        if (pos < act)                 return RGN_ACTIVE;
        else if (pos < act + fp)       return RGN_FRONT;
        else if (pos < act + fp + sync) return RGN_SYNC;
        else                           return RGN_BACK;
    endfunction

    // Address bits needed to cover a frame buffer of the given pixel count
    function automatic int addr_width(input int pixels);
        return (pixels <= 1) ? 1 : $clog2(pixels);
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int DEF_ADDR_W  = addr_width(DEF_H_ACTIVE * DEF_V_ACTIVE);

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Purpose : TFT-LCD timing bundle (syncs, DE, raster counters, frame-buffer prefetch address).
// Latency : n/a (wiring only).
// Backpressure: none; the raster free-runs on the pixel clock.
interface lcd_timing_gen_if #(
    parameter int ADDR_W = 17
);
    logic              Hsync;
    logic              Vsync;
    logic              DE;
    logic [9:0]        H_COUNT;
    logic [9:0]        V_COUNT;
    logic [ADDR_W-1:0] BRAMADDR;
    logic              FRAME_START;

    // Timing generator drives everything
    modport master (
        output Hsync, Vsync, DE, H_COUNT, V_COUNT, BRAMADDR, FRAME_START
    );

    // LCD controller / tracker / BRAM consume everything
    modport slave (
        input  Hsync, Vsync, DE, H_COUNT, V_COUNT, BRAMADDR, FRAME_START
    );
endinterface

// File: rtl/lcd_timing_gen_axis_counter.sv
// Purpose : one raster axis: wrapping position counter with step enable, wrap flag and region decode.
// Latency : count is registered; *_nxt decodes describe the value loaded at the coming edge.
// Backpressure: none; advances whenever i_step is high.
module lcd_axis_counter
    import lcd_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = DEF_H_ACTIVE,
    parameter int FP_LEN     = DEF_H_FP,
    parameter int SYNC_LEN   = DEF_H_SYNC,
    parameter int BP_LEN     = DEF_H_BP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_step,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap,
    output logic             o_active_nxt,
    output logic             o_sync_nxt
);

    localparam int               TOTAL = axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    region_e          w_region_nxt;

    // Next position: step and wrap at the last position of the axis
    always_comb begin
        w_count_nxt = r_count;
        if (i_step) begin
            w_count_nxt = (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    // Position register; reset parks on the last back-porch position so the first step lands on 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= LAST;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign w_region_nxt = region_of(int'(w_count_nxt), ACTIVE_LEN, FP_LEN, SYNC_LEN);

    assign o_count      = r_count;
    assign o_wrap       = (r_count == LAST);
    assign o_active_nxt = (w_region_nxt == RGN_ACTIVE);
    assign o_sync_nxt   = (w_region_nxt == RGN_SYNC);

endmodule

// File: rtl/lcd_timing_gen.sv
// Purpose : TFT-LCD raster timing (Hsync/Vsync/DE/counters/FRAME_START) plus BRAM prefetch address
//           one cycle ahead of DE. Build macro LCD_TIMING_REVERSE_SCAN_EN makes the address count down.
// Latency : all outputs registered; BRAMADDR leads the matching DE pixel by exactly one cycle.
// Backpressure: none; free-running on the pixel clock, synchronous RESET restarts the frame.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int ADDR_W          = DEF_ADDR_W
) (
    input  logic         CLK,
    input  logic         RESET,
    lcd_timing_gen_if.master lcd
);

    localparam int                PIXELS      = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(PIXELS - 1);
    localparam logic              SYNC_ASSERT = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
`ifdef LCD_TIMING_REVERSE_SCAN_EN
    localparam logic [ADDR_W-1:0] ADDR_INIT   = ADDR_LAST;
`else
    localparam logic [ADDR_W-1:0] ADDR_INIT   = '0;
`endif

    logic [CNT_W-1:0]  w_h_count;
    logic [CNT_W-1:0]  w_v_count;
    logic              w_h_wrap;
    logic              w_v_wrap;
    logic              w_h_active_nxt;
    logic              w_v_active_nxt;
    logic              w_h_sync_nxt;
    logic              w_v_sync_nxt;
    logic              w_de_nxt;
    logic              w_fs_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;

    logic              r_de;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_frame_start;
    logic [ADDR_W-1:0] r_addr;

    lcd_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP)
    ) u_h_axis (
        .i_clk        (CLK),
        .i_rst        (RESET),
        .i_step       (1'b1),
        .o_count      (w_h_count),
        .o_wrap       (w_h_wrap),
        .o_active_nxt (w_h_active_nxt),
        .o_sync_nxt   (w_h_sync_nxt)
    );

    // Vertical axis steps only when the line wraps, so Vsync edges line up with H_COUNT = 0
    lcd_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP)
    ) u_v_axis (
        .i_clk        (CLK),
        .i_rst        (RESET),
        .i_step       (w_h_wrap),
        .o_count      (w_v_count),
        .o_wrap       (w_v_wrap),
        .o_active_nxt (w_v_active_nxt),
        .o_sync_nxt   (w_v_sync_nxt)
    );

    // Decode of the position the counters move to at the coming edge
    assign w_de_nxt = w_h_active_nxt & w_v_active_nxt;
    assign w_fs_nxt = w_h_wrap & w_v_wrap;

    // Prefetch address: advance whenever the coming cycle shows a pixel, wrapping after the last one
    always_comb begin
        w_addr_nxt = r_addr;
        if (w_de_nxt) begin
`ifdef LCD_TIMING_REVERSE_SCAN_EN
            w_addr_nxt = (r_addr == '0) ? ADDR_LAST : r_addr - 1'b1;
`else
            w_addr_nxt = (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
`endif
        end
    end

    // Output registers; reset shows the idle last back-porch position with pixel 0 prefetched
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_de          <= 1'b0;
            r_hsync       <= ~SYNC_ASSERT;
            r_vsync       <= ~SYNC_ASSERT;
            r_frame_start <= 1'b0;
            r_addr        <= ADDR_INIT;
        end else begin
            r_de          <= w_de_nxt;
            r_hsync       <= w_h_sync_nxt ? SYNC_ASSERT : ~SYNC_ASSERT;
            r_vsync       <= w_v_sync_nxt ? SYNC_ASSERT : ~SYNC_ASSERT;
            r_frame_start <= w_fs_nxt;
            r_addr        <= w_addr_nxt;
        end
    end

    assign lcd.H_COUNT     = w_h_count;
    assign lcd.V_COUNT     = w_v_count;
    assign lcd.DE          = r_de;
    assign lcd.Hsync       = r_hsync;
    assign lcd.Vsync       = r_vsync;
    assign lcd.FRAME_START = r_frame_start;
    assign lcd.BRAMADDR    = r_addr;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Purpose : scoreboard bench for lcd_timing_gen on a scaled-down raster so several whole frames fit.
// Latency : expected state is pushed per clock edge and compared half a cycle later.
// Backpressure: none.
module tb_lcd_timing_gen;

    // Scaled raster: same region ordering, small enough to run many frames
    localparam int HA = 16, HF = 2, HS = 5, HB = 3;
    localparam int VA = 6,  VF = 2, VS = 3, VB = 2;
    localparam int SAL = 1;
    localparam int AW  = 7;
    localparam int HT   = HA + HF + HS + HB;
    localparam int VT   = VA + VF + VS + VB;
    localparam int FT   = HT * VT;
    localparam int NPIX = HA * VA;
    localparam logic SYNC_ON = (SAL != 0) ? 1'b0 : 1'b1;

    typedef struct {
        logic rst;
        int   h;
        int   v;
        logic de;
        logic hs;
        logic vs;
        logic fs;
        int   addr;
        int   pix;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    lcd_timing_gen_if #(.ADDR_W(AW)) lcd();

    lcd_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_ACTIVE_LOW (SAL), .ADDR_W (AW)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .lcd   (lcd)
    );

    always #5 CLK = ~CLK;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mpos;

    // Reference: everything follows from the linear position p within the frame
    function automatic exp_t model_at(input int p, input logic r);
        exp_t e;
        int h, v, q, qh, qv, idx;
        h = p % HT;
        v = p / HT;
        e.rst = r;
        e.h   = h;
        e.v   = v;
        e.de  = (h < HA) && (v < VA);
        e.hs  = (h >= HA + HF && h < HA + HF + HS) ? SYNC_ON : ~SYNC_ON;
        e.vs  = (v >= VA + VF && v < VA + VF + VS) ? SYNC_ON : ~SYNC_ON;
        e.fs  = (p == 0);
        // Address shown now = next visible pixel to come (0 once the frame's pixels are exhausted)
        q  = (p + 1) % FT;
        qh = q % HT;
        qv = q / HT;
        if (qv >= VA)           idx = 0;
        else if (qh < HA)       idx = qv * HA + qh;
        else if (qv + 1 < VA)   idx = (qv + 1) * HA;
        else                    idx = 0;
`ifdef LCD_TIMING_REVERSE_SCAN_EN
        e.addr = NPIX - 1 - idx;
        e.pix  = NPIX - 1 - (v * HA + h);
`else
        e.addr = idx;
        e.pix  = v * HA + h;
`endif
        return e;
    endfunction

    // Drive RESET for one edge and record what that edge must produce
    task automatic issue(input logic r);
        RESET = r;
        @(posedge CLK);
        mpos = r ? FT - 1 : (mpos + 1) % FT;
        sb.push_back(model_at(mpos, r));
        #1;
    endtask

    // BRAM with one cycle of read latency, data = address
    logic [AW-1:0] bram_q = '0;
    always @(posedge CLK) bram_q <= lcd.BRAMADDR;

    // Monitor: compare each recorded edge and collect per-frame aggregates
    int  cyc = 0;
    int  last_fs = 0;
    int  de_cnt = 0, hs_cnt = 0, vs_cnt = 0;
    bit  clean = 1'b0, have_prev = 1'b0;

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [AW-1:0] ea;
            e  = sb.pop_front();
            ea = AW'(e.addr);
            cyc++;

            total++;
            if (lcd.H_COUNT !== 10'(e.h) || lcd.V_COUNT !== 10'(e.v)) begin
                bad++;
                $display("FAIL counters cyc=%0d got h=%0d v=%0d want h=%0d v=%0d",
                         cyc, lcd.H_COUNT, lcd.V_COUNT, e.h, e.v);
            end
            total++;
            if (lcd.DE !== e.de || lcd.Hsync !== e.hs || lcd.Vsync !== e.vs || lcd.FRAME_START !== e.fs) begin
                bad++;
                $display("FAIL controls cyc=%0d (h=%0d v=%0d) got de=%b hs=%b vs=%b fs=%b want de=%b hs=%b vs=%b fs=%b",
                         cyc, e.h, e.v, lcd.DE, lcd.Hsync, lcd.Vsync, lcd.FRAME_START, e.de, e.hs, e.vs, e.fs);
            end
            total++;
            if (lcd.BRAMADDR !== ea) begin
                bad++;
                $display("FAIL bramaddr cyc=%0d (h=%0d v=%0d rst=%b) got %0d want %0d",
                         cyc, e.h, e.v, e.rst, lcd.BRAMADDR, e.addr);
            end
            if (e.de) begin
                total++;
                if (bram_q !== AW'(e.pix)) begin
                    bad++;
                    $display("FAIL pixel_data cyc=%0d (h=%0d v=%0d) got %0d want %0d",
                             cyc, e.h, e.v, bram_q, e.pix);
                end
            end

            if (e.rst) clean = 1'b0;
            if (lcd.FRAME_START === 1'b1) begin
                if (clean && have_prev) begin
                    total++;
                    if (cyc - last_fs != FT) begin
                        bad++;
                        $display("FAIL frame_period got %0d want %0d", cyc - last_fs, FT);
                    end
                    total++;
                    if (de_cnt != NPIX) begin
                        bad++;
                        $display("FAIL de_per_frame got %0d want %0d", de_cnt, NPIX);
                    end
                    total++;
                    if (hs_cnt != VT * HS) begin
                        bad++;
                        $display("FAIL hsync_per_frame got %0d want %0d", hs_cnt, VT * HS);
                    end
                    total++;
                    if (vs_cnt != VS * HT) begin
                        bad++;
                        $display("FAIL vsync_per_frame got %0d want %0d", vs_cnt, VS * HT);
                    end
                end
                last_fs   = cyc;
                de_cnt    = 0;
                hs_cnt    = 0;
                vs_cnt    = 0;
                clean     = 1'b1;
                have_prev = 1'b1;
            end
            if (lcd.DE === 1'b1)        de_cnt++;
            if (lcd.Hsync === SYNC_ON)  hs_cnt++;
            if (lcd.Vsync === SYNC_ON)  vs_cnt++;
        end
    end

    initial begin
        int n;
        mpos = FT - 1;
        RESET = 1'b1;

        // Reset held for 5 clocks, then several clean frames
        repeat (5) issue(1'b1);
        repeat (3 * FT) issue(1'b0);

        // One-clock reset pulse mid-frame at (h=10, v=3)
        n = 0;
        while (mpos != 3 * HT + 10 && n < FT) begin
            issue(1'b0);
            n++;
        end
        issue(1'b1);
        repeat (FT + 50) issue(1'b0);

        // Random reset bursts of 1..4 clocks
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                n = $urandom_range(1, 4);
                repeat (n) issue(1'b1);
            end else begin
                issue(1'b0);
            end
        end
        repeat (2 * FT + 10) issue(1'b0);

        @(negedge CLK);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
